// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus among NUM_MASTERS requesters.
// Grants are registered and one-hot. Arbitration is round-robin or fixed priority.
// A locking owner is forced off the bus after MAX_LOCK contended cycles.
// Read returns are steered back to the issuing master via a tag pipeline.
module mem_bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int RD_LATENCY  = 1,
  parameter int RR_MODE     = 1,
  parameter int MAX_LOCK    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        req,
  input  logic [NUM_MASTERS-1:0]        lock,
  input  logic [NUM_MASTERS-1:0]        we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] wdata,
  output logic [NUM_MASTERS-1:0]        gnt,
  output logic [NUM_MASTERS-1:0]        rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic                          lock_violation,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_data_out,
  output logic                          mem_write_en,
  output logic                          mem_read_en,
  input  logic [DATA_W-1:0]             mem_data_in
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {S_IDLE, S_OWNED} state_t;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_gnt;
  idx_t                   r_owner;
  idx_t                   r_last_owner;
  logic [CNT_W-1:0]       r_lock_cnt;
  logic                   r_lock_violation;
  logic [RD_LATENCY-1:0]  r_tag_v;
  idx_t                   r_tag_idx [RD_LATENCY];

  logic                   w_access;
  logic                   w_others_waiting;
  logic                   w_owner_lock;
  logic                   w_force;
  logic                   w_hold;
  logic [NUM_MASTERS-1:0] w_cand;
  idx_t                   w_start;
  logic                   w_found;
  idx_t                   w_win;

  function automatic logic [NUM_MASTERS-1:0] onehot(input idx_t i);
    logic [NUM_MASTERS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Lock bookkeeping: decide whether the owner keeps the bus or is forced off.
  always_comb begin
    w_others_waiting = |(req & ~r_gnt);
    w_owner_lock     = (r_state == S_OWNED) && lock[r_owner];
    w_force          = w_owner_lock && w_others_waiting &&
                       (r_lock_cnt == CNT_W'(MAX_LOCK - 1));
    w_hold           = w_owner_lock && !w_force;
    // A forced release must hand the bus to someone else.
    w_cand           = w_force ? (req & ~r_gnt) : req;
  end

  // Search start: fixed priority always begins at 0, round-robin just past the
  // last owner (which equals the current owner while the bus is owned).
  always_comb begin
    if (RR_MODE == 0) begin
      w_start = '0;
    end else if (r_last_owner == idx_t'(NUM_MASTERS - 1)) begin
      w_start = '0;
    end else begin
      w_start = r_last_owner + idx_t'(1);
    end
  end

  // Winner search over candidates, wrapping from w_start.
  always_comb begin
    int unsigned j;
    j       = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      j = (32'(w_start) + k) % NUM_MASTERS;
      if (!w_found && w_cand[j]) begin
        w_found = 1'b1;
        w_win   = idx_t'(j);
      end
    end
  end

  // Ownership FSM with lock counter and sticky violation flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= S_IDLE;
      r_gnt            <= '0;
      r_owner          <= '0;
      r_last_owner     <= idx_t'(NUM_MASTERS - 1);
      r_lock_cnt       <= '0;
      r_lock_violation <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_lock_cnt <= '0;
          if (w_found) begin
            r_state      <= S_OWNED;
            r_gnt        <= onehot(w_win);
            r_owner      <= w_win;
            r_last_owner <= w_win;
          end
        end
        S_OWNED: begin
          if (w_hold) begin
            r_lock_cnt <= w_others_waiting ? (r_lock_cnt + CNT_W'(1)) : '0;
          end else if (w_found) begin
            if (w_force) begin
              r_lock_violation <= 1'b1;
            end
            r_gnt        <= onehot(w_win);
            r_owner      <= w_win;
            r_last_owner <= w_win;
            r_lock_cnt   <= '0;
          end else begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_lock_cnt <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  // Memory bus mux: only the granted and requesting master drives the bus.
  always_comb begin
    w_access     = |(r_gnt & req);
    mem_addr     = '0;
    mem_data_out = '0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    if (w_access) begin
      mem_addr     = addr[r_owner*ADDR_W +: ADDR_W];
      mem_data_out = wdata[r_owner*DATA_W +: DATA_W];
      mem_write_en = we[r_owner];
      mem_read_en  = ~we[r_owner];
    end
  end

  // Read tag pipeline: remembers which master issued each read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_v <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        r_tag_idx[i] <= '0;
      end
    end else begin
      r_tag_v[0]   <= mem_read_en;
      r_tag_idx[0] <= r_owner;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
    end
  end

  // Read-valid strobe decoded from the last pipeline stage.
  always_comb begin
    rvalid = '0;
    if (r_tag_v[RD_LATENCY-1]) begin
      rvalid[r_tag_idx[RD_LATENCY-1]] = 1'b1;
    end
  end

  assign rdata          = mem_data_in;
  assign gnt            = r_gnt;
  assign lock_violation = r_lock_violation;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed table-driven checks of mem_bus_arbiter.
// Two instances share stimulus: round-robin (u_rr) and fixed priority (u_fp),
// both with RD_LATENCY=2 and MAX_LOCK=4.
module tb_mem_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, lock, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0] mem_data_in;

  logic [N-1:0]  rr_gnt, rr_rvalid, fp_gnt, fp_rvalid;
  logic [DW-1:0] rr_rdata, fp_rdata, rr_mdout, fp_mdout;
  logic [AW-1:0] rr_maddr, fp_maddr;
  logic          rr_lv, fp_lv, rr_mwe, fp_mwe, rr_mre, fp_mre;

  mem_bus_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
    .RD_LATENCY(2), .RR_MODE(1), .MAX_LOCK(4)
  ) u_rr (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr),
    .wdata(wdata), .gnt(rr_gnt), .rvalid(rr_rvalid), .rdata(rr_rdata),
    .lock_violation(rr_lv), .mem_addr(rr_maddr), .mem_data_out(rr_mdout),
    .mem_write_en(rr_mwe), .mem_read_en(rr_mre), .mem_data_in(mem_data_in)
  );

  mem_bus_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
    .RD_LATENCY(2), .RR_MODE(0), .MAX_LOCK(4)
  ) u_fp (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr),
    .wdata(wdata), .gnt(fp_gnt), .rvalid(fp_rvalid), .rdata(fp_rdata),
    .lock_violation(fp_lv), .mem_addr(fp_maddr), .mem_data_out(fp_mdout),
    .mem_write_en(fp_mwe), .mem_read_en(fp_mre), .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] req;
    logic [2:0] lock;
    logic [2:0] g_rr;
    logic [2:0] g_fp;
    logic       lv;
  } vec_t;

  vec_t tbl [30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic [2:0] r, input logic [2:0] l,
                     input logic [2:0] grr, input logic [2:0] gfp, input logic v);
    tbl[i] = '{req: r, lock: l, g_rr: grr, g_fp: gfp, lv: v};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b0; req = '0; lock = '0; we = '0;
    addr = '0; wdata = '0; mem_data_in = '0;

    // req, lock -> gnt after the next edge (rr, fp), lock_violation
    put( 0, 3'b111, 3'b000, 3'b001, 3'b001, 1'b0);
    put( 1, 3'b111, 3'b000, 3'b010, 3'b001, 1'b0);
    put( 2, 3'b111, 3'b000, 3'b100, 3'b001, 1'b0);
    put( 3, 3'b111, 3'b000, 3'b001, 3'b001, 1'b0);
    put( 4, 3'b111, 3'b000, 3'b010, 3'b001, 1'b0);
    put( 5, 3'b111, 3'b000, 3'b100, 3'b001, 1'b0);
    put( 6, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    put( 7, 3'b110, 3'b000, 3'b010, 3'b010, 1'b0);
    put( 8, 3'b111, 3'b000, 3'b100, 3'b001, 1'b0);
    put( 9, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    put(10, 3'b001, 3'b001, 3'b001, 3'b001, 1'b0);
    put(11, 3'b101, 3'b001, 3'b001, 3'b001, 1'b0);
    put(12, 3'b101, 3'b001, 3'b001, 3'b001, 1'b0);
    put(13, 3'b101, 3'b001, 3'b001, 3'b001, 1'b0);
    put(14, 3'b101, 3'b001, 3'b100, 3'b100, 1'b1);
    put(15, 3'b101, 3'b000, 3'b001, 3'b001, 1'b1);
    put(16, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
    put(17, 3'b011, 3'b100, 3'b010, 3'b001, 1'b1);
    put(18, 3'b011, 3'b100, 3'b001, 3'b001, 1'b1);
    put(19, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
    put(20, 3'b001, 3'b001, 3'b001, 3'b001, 1'b1);
    put(21, 3'b101, 3'b001, 3'b001, 3'b001, 1'b1);
    put(22, 3'b101, 3'b001, 3'b001, 3'b001, 1'b1);
    put(23, 3'b101, 3'b001, 3'b001, 3'b001, 1'b1);
    put(24, 3'b001, 3'b001, 3'b001, 3'b001, 1'b1);
    put(25, 3'b101, 3'b001, 3'b001, 3'b001, 1'b1);
    put(26, 3'b101, 3'b001, 3'b001, 3'b001, 1'b1);
    put(27, 3'b101, 3'b001, 3'b001, 3'b001, 1'b1);
    put(28, 3'b101, 3'b001, 3'b100, 3'b100, 1'b1);
    put(29, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);

    // Reset state, with requests and addresses driven while held in reset.
    req = 3'b111; we = 3'b010; addr = {16'h3333, 16'h2222, 16'h1111};
    repeat (2) @(posedge clk);
    #2;
    chk("reset gnt rr", 32'(rr_gnt), 32'h0);
    chk("reset gnt fp", 32'(fp_gnt), 32'h0);
    chk("reset rvalid", 32'(rr_rvalid), 32'h0);
    chk("reset lock_violation", 32'(rr_lv), 32'h0);
    chk("reset mem_addr", 32'(rr_maddr), 32'h0);
    chk("reset mem_we/re", {30'h0, rr_mwe, rr_mre}, 32'h0);
    req = '0; we = '0;
    #1 rst = 1'b1;

    // Table-driven arbitration vectors.
    for (int i = 0; i < 30; i++) begin
      req  = tbl[i].req;
      lock = tbl[i].lock;
      tick();
      chk($sformatf("vec%0d gnt rr", i), 32'(rr_gnt), 32'(tbl[i].g_rr));
      chk($sformatf("vec%0d gnt fp", i), 32'(fp_gnt), 32'(tbl[i].g_fp));
      chk($sformatf("vec%0d lock_violation rr", i), 32'(rr_lv), 32'(tbl[i].lv));
      chk($sformatf("vec%0d lock_violation fp", i), 32'(fp_lv), 32'(tbl[i].lv));
    end

    // Clean reset between sequences.
    req = '0; lock = '0; we = '0;
    #2 rst = 1'b0;
    tick();
    #2 rst = 1'b1;
    tick();
    chk("reset clears lock_violation", 32'(rr_lv), 32'h0);

    // Read by master 1 with two-cycle return latency.
    addr = {16'hAAAA, 16'h2002, 16'h1111};
    wdata = {8'h77, 8'h66, 8'h55};
    mem_data_in = 8'hC3;
    req = 3'b010;
    tick();
    #1;
    chk("read gnt", 32'(rr_gnt), 32'h2);
    chk("read mem_read_en", 32'(rr_mre), 32'h1);
    chk("read mem_write_en", 32'(rr_mwe), 32'h0);
    chk("read mem_addr", 32'(rr_maddr), 32'h2002);
    chk("read rvalid early0", 32'(rr_rvalid), 32'h0);
    tick();
    req = '0;
    #1;
    chk("read rvalid early1", 32'(rr_rvalid), 32'h0);
    chk("idle bus mem_addr", 32'(rr_maddr), 32'h0);
    chk("idle bus mem_re", 32'(rr_mre), 32'h0);
    tick();
    chk("read rvalid rr", 32'(rr_rvalid), 32'h2);
    chk("read rvalid fp", 32'(fp_rvalid), 32'h2);
    chk("read rdata", 32'(rr_rdata), 32'hC3);
    chk("read gnt after drop", 32'(rr_gnt), 32'h0);
    tick();
    chk("read rvalid late", 32'(rr_rvalid), 32'h0);

    // Write by master 2; other masters' addr/wdata/we must not leak.
    addr = {16'h4014, 16'h2002, 16'h1111};
    wdata = {8'h5A, 8'h66, 8'h55};
    we = 3'b101;
    req = 3'b100;
    tick();
    #1;
    chk("write gnt", 32'(rr_gnt), 32'h4);
    chk("write mem_write_en", 32'(rr_mwe), 32'h1);
    chk("write mem_read_en", 32'(rr_mre), 32'h0);
    chk("write mem_addr", 32'(rr_maddr), 32'h4014);
    chk("write mem_data_out", 32'(rr_mdout), 32'h5A);
    tick();
    req = '0; we = '0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      #2;
      if (rr_rvalid != '0) seen++;
      tick();
    end
    chk("write produced no rvalid", 32'(seen), 32'h0);

    // Read by master 0, then reset pulsed before the return arrives.
    req = 3'b001;
    tick();
    #1;
    chk("midreset read issued", 32'(rr_mre), 32'h1);
    tick();
    req = '0;
    rst = 1'b0;
    #1;
    chk("midreset async gnt clear", 32'(rr_gnt), 32'h0);
    #1 rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      #2;
      if (rr_rvalid != '0 || fp_rvalid != '0) seen++;
      if (rr_gnt != '0) seen++;
      tick();
    end
    chk("midreset no rvalid/gnt after release", 32'(seen), 32'h0);

    // First grant only at the first rising edge after reset release.
    #1 rst = 1'b0;
    req = 3'b001;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("no grant before first edge", 32'(rr_gnt), 32'h0);
    tick();
    chk("grant at first edge", 32'(rr_gnt), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
